// File: rtl/effect_sequencer.sv
// -----------------------------------------------------------------------------
// effect_sequencer
//   Queues 4-bit decoration opcodes in a small in-order FIFO and executes them
//   one at a time. Light colour and power changes take a single cycle. Sound
//   and movement effects hold their enable for a fixed number of cycles, and
//   no further command is popped while an effect is running.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active low (flushes FIFO, aborts holds)
//   cmd_valid  in   upstream presents an opcode
//   cmd_op     in   [3:0] opcode
//   cmd_ready  out  FIFO not full; transfer on cmd_valid && cmd_ready
//   powered    out  decoration switched on
//   color      out  [1:0] 00 off, 01 green, 10 purple, 11 orange
//   sound_en   out  sound effect active
//   sound_sel  out  [1:0] 00 scream, 01 cackle, 10 boo (holds last value)
//   move_en    out  actuator active
//   move_sel   out  [1:0] 00 wave hands, 01 move jaw, 10 fog (holds last value)
//   busy       out  FIFO non-empty or an effect in progress
//   drop_cnt   out  [3:0] saturating count of discarded commands
// -----------------------------------------------------------------------------
module effect_sequencer #(
  parameter int DEPTH     = 4,
  parameter int SOUND_CYC = 8,
  parameter int MOVE_CYC  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_op,
  output logic       cmd_ready,
  output logic       powered,
  output logic [1:0] color,
  output logic       sound_en,
  output logic [1:0] sound_sel,
  output logic       move_en,
  output logic [1:0] move_sel,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_CYC = (SOUND_CYC > MOVE_CYC) ? SOUND_CYC : MOVE_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [3:0] OP_ON     = 4'b0000;
  localparam logic [3:0] OP_RESET  = 4'b0001;
  localparam logic [3:0] OP_GREEN  = 4'b0100;
  localparam logic [3:0] OP_PURPLE = 4'b0101;
  localparam logic [3:0] OP_ORANGE = 4'b0110;
  localparam logic [3:0] OP_SCREAM = 4'b1000;
  localparam logic [3:0] OP_CACKLE = 4'b1001;
  localparam logic [3:0] OP_BOO    = 4'b1010;
  localparam logic [3:0] OP_WAVE   = 4'b1100;
  localparam logic [3:0] OP_JAW    = 4'b1101;
  localparam logic [3:0] OP_FOG    = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_SOUND, S_MOVE} state_t;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
  logic [3:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  state_t        r_state,     w_state_nx;
  logic [CW-1:0] r_cnt,       w_cnt_nx;
  logic          r_powered,   w_powered_nx;
  logic [1:0]    r_color,     w_color_nx;
  logic          r_sound_en,  w_sound_en_nx;
  logic [1:0]    r_sound_sel, w_sound_sel_nx;
  logic          r_move_en,   w_move_en_nx;
  logic [1:0]    r_move_sel,  w_move_sel_nx;
  logic [3:0]    r_drop_cnt,  w_drop_cnt_nx;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic [3:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Ready comes from registered pointers only, so a pop in this cycle never
  // opens a slot for a push in the same cycle.
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; flushing is done by resetting the
  // pointers, and stale entries are unreachable until overwritten.
  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= cmd_op;
  end

  always_comb begin
    // NOTE: every target gets a default before any branch, otherwise paths
    // that skip an assignment would infer latches.
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_powered_nx   = r_powered;
    w_color_nx     = r_color;
    w_sound_en_nx  = r_sound_en;
    w_sound_sel_nx = r_sound_sel;
    w_move_en_nx   = r_move_en;
    w_move_sel_nx  = r_move_sel;
    w_drop         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          case (w_head)
            OP_ON:    w_powered_nx = 1'b1;
            OP_RESET: begin
              w_powered_nx  = 1'b0;
              w_color_nx    = 2'b00;
              w_sound_en_nx = 1'b0;
              w_move_en_nx  = 1'b0;
            end
            OP_GREEN, OP_PURPLE, OP_ORANGE: begin
              // 0100/0101/0110 map onto colour codes 01/10/11.
              if (r_powered) w_color_nx = w_head[1:0] + 2'd1;
              else           w_drop     = 1'b1;
            end
            OP_SCREAM, OP_CACKLE, OP_BOO: begin
              if (r_powered) begin
                w_sound_sel_nx = w_head[1:0];
                w_sound_en_nx  = 1'b1;
                w_cnt_nx       = CW'(SOUND_CYC - 1);
                w_state_nx     = S_SOUND;
              end else begin
                w_drop = 1'b1;
              end
            end
            OP_WAVE, OP_JAW, OP_FOG: begin
              if (r_powered) begin
                w_move_sel_nx = w_head[1:0];
                w_move_en_nx  = 1'b1;
                w_cnt_nx      = CW'(MOVE_CYC - 1);
                w_state_nx    = S_MOVE;
              end else begin
                w_drop = 1'b1;
              end
            end
            default: w_drop = 1'b1;
          endcase
        end
      end
      // The counter is loaded with HOLD-1 on entry, so the enable is seen
      // high for exactly HOLD cycles before the state returns to IDLE.
      S_SOUND: begin
        if (r_cnt == '0) begin
          w_sound_en_nx = 1'b0;
          w_state_nx    = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_MOVE: begin
        if (r_cnt == '0) begin
          w_move_en_nx = 1'b0;
          w_state_nx   = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    w_drop_cnt_nx = r_drop_cnt;
    if (w_drop && (r_drop_cnt != 4'hF)) w_drop_cnt_nx = r_drop_cnt + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_powered   <= 1'b0;
      r_color     <= 2'b00;
      r_sound_en  <= 1'b0;
      r_sound_sel <= 2'b00;
      r_move_en   <= 1'b0;
      r_move_sel  <= 2'b00;
      r_drop_cnt  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_powered   <= w_powered_nx;
      r_color     <= w_color_nx;
      r_sound_en  <= w_sound_en_nx;
      r_sound_sel <= w_sound_sel_nx;
      r_move_en   <= w_move_en_nx;
      r_move_sel  <= w_move_sel_nx;
      r_drop_cnt  <= w_drop_cnt_nx;
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign powered   = r_powered;
  assign color     = r_color;
  assign sound_en  = r_sound_en;
  assign sound_sel = r_sound_sel;
  assign move_en   = r_move_en;
  assign move_sel  = r_move_sel;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_effect_sequencer.sv
// -----------------------------------------------------------------------------
// tb_effect_sequencer
//   Directed stimulus for effect_sequencer. Each issued command runs through a
//   small behavioural model that queues the output snapshots it should cause
//   (plus the cycle distance from the previous change where that is fixed).
//   An independent monitor compares every observed output change against the
//   head of that queue. Direct checks cover latency, flow control and reset.
// -----------------------------------------------------------------------------
module tb_effect_sequencer;

  localparam int DEPTH     = 4;
  localparam int SOUND_CYC = 8;
  localparam int MOVE_CYC  = 6;

  localparam logic [3:0] OP_ON     = 4'b0000;
  localparam logic [3:0] OP_RESET  = 4'b0001;
  localparam logic [3:0] OP_GREEN  = 4'b0100;
  localparam logic [3:0] OP_PURPLE = 4'b0101;
  localparam logic [3:0] OP_ORANGE = 4'b0110;
  localparam logic [3:0] OP_SCREAM = 4'b1000;
  localparam logic [3:0] OP_CACKLE = 4'b1001;
  localparam logic [3:0] OP_BOO    = 4'b1010;
  localparam logic [3:0] OP_WAVE   = 4'b1100;
  localparam logic [3:0] OP_JAW    = 4'b1101;
  localparam logic [3:0] OP_FOG    = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic       cmd_ready;
  logic       powered;
  logic [1:0] color;
  logic       sound_en;
  logic [1:0] sound_sel;
  logic       move_en;
  logic [1:0] move_sel;
  logic       busy;
  logic [3:0] drop_cnt;

  effect_sequencer #(
    .DEPTH    (DEPTH),
    .SOUND_CYC(SOUND_CYC),
    .MOVE_CYC (MOVE_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_ready(cmd_ready),
    .powered  (powered),
    .color    (color),
    .sound_en (sound_en),
    .sound_sel(sound_sel),
    .move_en  (move_en),
    .move_sel (move_sel),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Snapshot layout: {powered, color, sound_en, sound_sel, move_en, move_sel, drop_cnt}
  typedef struct {
    logic [12:0] outs;
    int          gap;   // negedges since previous change, -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [12:0] dut_snap();
    return {powered, color, sound_en, sound_sel, move_en, move_sel, drop_cnt};
  endfunction

  // ---------------- behavioural model ----------------
  logic       m_pw   = 1'b0;
  logic [1:0] m_col  = 2'b00;
  logic       m_sen  = 1'b0;
  logic [1:0] m_ssel = 2'b00;
  logic       m_men  = 1'b0;
  logic [1:0] m_msel = 2'b00;
  logic [3:0] m_drop = 4'd0;
  logic [12:0] m_last = '0;

  function automatic void m_push(input int gap);
    logic [12:0] s;
    exp_t e;
    s = {m_pw, m_col, m_sen, m_ssel, m_men, m_msel, m_drop};
    if (s != m_last) begin
      e.outs = s;
      e.gap  = gap;
      exp_q.push_back(e);
      m_last = s;
    end
  endfunction

  function automatic void m_exec(input logic [3:0] op, input int gap, input bit full_hold);
    bit drop;
    drop = 1'b0;
    case (op)
      OP_ON:     m_pw = 1'b1;
      OP_RESET:  begin m_pw = 1'b0; m_col = 2'b00; m_sen = 1'b0; m_men = 1'b0; end
      OP_GREEN:  if (m_pw) m_col = 2'b01; else drop = 1'b1;
      OP_PURPLE: if (m_pw) m_col = 2'b10; else drop = 1'b1;
      OP_ORANGE: if (m_pw) m_col = 2'b11; else drop = 1'b1;
      OP_SCREAM, OP_CACKLE, OP_BOO: begin
        if (m_pw) begin
          m_ssel = (op == OP_SCREAM) ? 2'b00 : (op == OP_CACKLE) ? 2'b01 : 2'b10;
          m_sen  = 1'b1;
          m_push(gap);
          if (full_hold) begin
            m_sen = 1'b0;
            m_push(SOUND_CYC);
          end
          return;
        end
        drop = 1'b1;
      end
      OP_WAVE, OP_JAW, OP_FOG: begin
        if (m_pw) begin
          m_msel = (op == OP_WAVE) ? 2'b00 : (op == OP_JAW) ? 2'b01 : 2'b10;
          m_men  = 1'b1;
          m_push(gap);
          if (full_hold) begin
            m_men = 1'b0;
            m_push(MOVE_CYC);
          end
          return;
        end
        drop = 1'b1;
      end
      default: drop = 1'b1;
    endcase
    if (drop && m_drop != 4'hF) m_drop = m_drop + 4'd1;
    m_push(gap);
  endfunction

  // ---------------- monitor ----------------
  bit          mon_en  = 1'b0;
  logic [12:0] mon_prev;
  logic [12:0] mon_cur;
  int          mon_cyc;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = dut_snap();
      mon_cyc++;
      if (mon_cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_change", mon_cur, mon_prev);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_outputs", mon_cur, mon_e.outs);
          if (mon_e.gap >= 0) check("sb_gap", mon_cyc, mon_e.gap);
        end
        mon_prev = mon_cur;
        mon_cyc  = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_raw(input logic [3:0] op);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("send_ready_timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input int gap);
    m_exec(op, gap, 1'b1);
    send_raw(op);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 1'b0);
  endtask

  logic [3:0] fill_ops [4];
  int         acc;
  int         n_wait;

  initial begin
    fill_ops[0] = OP_WAVE;
    fill_ops[1] = OP_ORANGE;
    fill_ops[2] = OP_SCREAM;
    fill_ops[3] = OP_GREEN;

    // Reset with a command presented: it must not be captured.
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_ON;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("reset_outputs", dut_snap(), 13'd0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    #1;
    mon_prev = 13'd0;
    mon_cyc  = 0;
    mon_en   = 1'b1;

    // ON then GREEN: powered two cycles after accept, colour one cycle later.
    send(OP_ON, -1);
    @(negedge clk);
    check("on_pop_cycle_powered", powered, 1'b0);
    send(OP_GREEN, 1);
    @(negedge clk);
    check("on_latency_powered", powered, 1'b1);
    check("green_not_yet", color, 2'b00);
    @(negedge clk);
    check("green_color", color, 2'b01);
    repeat (2) @(negedge clk);
    check("busy_after_colour", busy, 1'b0);

    // BOO then JAW: 8-cycle sound hold, one idle cycle, 6-cycle move hold.
    send(OP_BOO, -1);
    send(OP_JAW, 1);
    check("busy_during_hold", busy, 1'b1);
    wait_idle();
    check("jaw_sel_held", move_sel, 2'b01);
    check("boo_sel_held", sound_sel, 2'b10);

    // Unpowered commands and undefined opcodes are discarded.
    send(OP_RESET, -1);
    send(OP_PURPLE, -1);
    send(4'b0010, -1);
    send(OP_FOG, -1);
    wait_idle();
    check("drop_cnt_3", drop_cnt, 4'd3);
    check("drop_color_unchanged", color, 2'b00);
    for (int i = 0; i < 14; i++) send(4'b0011, -1);
    wait_idle();
    check("drop_cnt_saturated", drop_cnt, 4'd15);

    // Fill the FIFO while a FOG hold runs.
    send(OP_ON, -1);
    send(OP_FOG, -1);
    n_wait = 0;
    while (!move_en && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    check("fog_started", move_en, 1'b1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      cmd_valid = 1'b1;
      cmd_op    = (acc < DEPTH) ? fill_ops[acc] : OP_CACKLE;
      if (cmd_ready) begin
        m_exec(cmd_op, 1, 1'b1);
        acc++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("fill_accepts", acc, DEPTH);
    check("fill_ready_low", cmd_ready, 1'b0);
    wait_idle();
    check("drain_color", color, 2'b01);

    // Reset during the third cycle of a SCREAM hold with two queued entries.
    m_exec(OP_SCREAM, -1, 1'b0);
    send_raw(OP_SCREAM);
    send_raw(OP_GREEN);
    send_raw(OP_WAVE);
    @(posedge clk); #1;
    check("scream_in_hold", sound_en, 1'b1);
    check("scream_queue_busy", busy, 1'b1);
    m_pw = 1'b0; m_col = 2'b00; m_sen = 1'b0; m_ssel = 2'b00;
    m_men = 1'b0; m_msel = 2'b00; m_drop = 4'd0;
    m_push(3);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_sound_en", sound_en, 1'b0);
    check("abort_outputs", dut_snap(), 13'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    repeat (10) @(negedge clk);
    check("abort_stays_quiet", dut_snap(), 13'd0);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/effect_sequencer.md
EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have parameter SOUND_CYC, default 8, meaning cycles sound_en stays high per sound command (at least 1).
REQ-003 The block SHALL have parameter MOVE_CYC, default 6, meaning cycles move_en stays high per movement/effect command (at least 1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  upstream presents an opcode this cycle.
REQ-007 cmd_op  input  4  opcode from the instruction-sequencing stage.
REQ-008 cmd_ready  output  1  FIFO can accept; a transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-009 powered  output  1  decoration is on.
REQ-010 color  output  2  light colour: 00 off, 01 green, 10 purple, 11 orange.
REQ-011 sound_en / sound_sel  output  1 / 2  sound active; sel 00 scream, 01 cackle, 10 boo.
REQ-012 move_en / move_sel  output  1 / 2  actuator active; sel 00 wave hands, 01 move jaw, 10 fog.
REQ-013 busy  output  1  FIFO non-empty or FSM not in IDLE.
REQ-014 drop_cnt  output  4  saturating count of discarded commands.

Function
REQ-015 Opcode map: 0000 ON, 0001 RESET, 0100 GREEN, 0101 PURPLE, 0110 ORANGE, 1000 SCREAM, 1001 CACKLE, 1010 BOO, 1100 WAVE, 1101 JAW, 1110 FOG; all other codes are undefined.
REQ-016 cmd_ready SHALL equal not-full as registered at the start of the cycle; a pop in the same cycle SHALL NOT allow a push when full.
REQ-017 FIFO SHALL be strictly in-order with wrap-around pointers; there is no bypass, so a pushed entry is poppable no earlier than the next cycle.
REQ-018 FSM states SHALL be IDLE, SOUND, MOVE.
REQ-019 In IDLE with the FIFO non-empty, the head SHALL be popped and executed; its outputs SHALL be visible the next cycle, which is 2 cycles after the accepting edge.
REQ-020 ON SHALL set powered=1; the FSM SHALL stay in IDLE.
REQ-021 RESET opcode SHALL clear powered, set color=00, clear sound_en and move_en, and leave the FIFO contents and drop_cnt unchanged; the FSM SHALL stay in IDLE.
REQ-022 GREEN/PURPLE/ORANGE while powered SHALL update color; the FSM SHALL stay in IDLE, so one colour command executes per cycle.
REQ-023 A sound opcode while powered SHALL set sound_sel, then hold sound_en=1 for exactly SOUND_CYC cycles in state SOUND, then drop sound_en and return to IDLE.
REQ-024 A movement opcode while powered SHALL set move_sel, then hold move_en=1 for exactly MOVE_CYC cycles in state MOVE, then drop move_en and return to IDLE.
REQ-025 There SHALL be exactly one IDLE cycle (a pop cycle) between the end of one hold and the start of the next effect; color SHALL persist across holds.
REQ-026 Colour, sound or movement opcodes popped while powered=0, and any undefined opcode, SHALL be discarded with no output change; drop_cnt SHALL increment and saturate at 15.
REQ-027 sound_sel and move_sel SHALL hold their last value when the corresponding enable is low.

Reset
REQ-028 With rst=0 at a rising edge: FIFO empty, state IDLE, powered=0, color=00, sound_en=0, move_en=0, sound_sel=00, move_sel=00, drop_cnt=0; cmd_ready=1 from the first cycle after reset.
REQ-029 Reset asserted mid-hold or with a non-empty FIFO SHALL abort the hold and flush all entries in that same edge.
REQ-030 Inputs presented while rst=0 SHALL be ignored (no push).

Verification
REQ-031 Reset, then push ON, GREEN -> powered=1 two cycles after the ON accept, then color=01 one cycle later; busy drops afterwards.
REQ-032 Push BOO, then JAW with SOUND_CYC=8 and MOVE_CYC=6 -> sound_en high 8 cycles with sel=10, 1 idle cycle, then move_en high 6 cycles with sel=01.
REQ-033 With powered=0, push PURPLE, 0010, FOG -> no output change, drop_cnt=3; 16 or more drops leave drop_cnt=15.
REQ-034 While a FOG hold runs, hold cmd_valid high -> exactly DEPTH accepts, then cmd_ready=0; entries drain in order with no loss or duplication.
REQ-035 Pulse rst low during the 3rd cycle of a SCREAM hold with 2 queued entries -> next cycle sound_en=0, FIFO empty, all outputs at their reset values.
